// File: rtl/w_route_ctrl_pkg.sv
// Shared AXI widths and the W-routing command payload.
package w_route_ctrl_pkg;

  localparam int unsigned ID_W        = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned LEN_W       = 4;
  localparam int unsigned NUM_M       = 3;
  localparam int unsigned NUM_S       = 7;
  localparam int unsigned MIDX_W      = 2;
  localparam int unsigned W_CMD_DEPTH = 2;

  typedef struct packed {
    logic [MIDX_W-1:0] master;
    logic [NUM_S-1:0]  slave;
    logic [LEN_W-1:0]  len;
  } w_cmd_t;

endpackage

// File: rtl/w_cmd_fifo.sv
// Circular command FIFO with occupancy counter; no same-cycle full bypass.
module w_cmd_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/w_route_ctrl.sv
// AXI W-channel router: queues AW routing commands and steers W beats from
// the owning master to the selected slave, regenerating WLAST from the count.
module w_route_ctrl
  import w_route_ctrl_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = W_CMD_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    aw_fire,
  input  logic [MIDX_W-1:0]       aw_master,
  input  logic [NUM_S-1:0]        aw_slave,
  input  logic [LEN_W-1:0]        aw_len,
  output logic                    aw_cmd_ready,
  input  logic [NUM_M*DATA_W-1:0] wdata_m,
  input  logic [NUM_M*STRB_W-1:0] wstrb_m,
  input  logic [NUM_M-1:0]        wlast_m,
  input  logic [NUM_M-1:0]        wvalid_m,
  output logic [NUM_M-1:0]        wready_m,
  output logic [DATA_W-1:0]       wdata_s,
  output logic [STRB_W-1:0]       wstrb_s,
  output logic                    wlast_s,
  output logic [NUM_S-1:0]        wvalid_s,
  input  logic [NUM_S-1:0]        wready_s,
  output logic                    w_len_err
);

  localparam int unsigned CMD_W = $bits(w_cmd_t);
  localparam int unsigned CNT_W = $clog2(CMD_DEPTH + 1);

  w_cmd_t             w_push_cmd;
  w_cmd_t             w_head;
  logic [CMD_W-1:0]   w_head_raw;
  logic [CNT_W-1:0]   w_count;
  logic               w_unused_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_active;
  logic               w_mvalid;
  logic               w_mlast;
  logic [DATA_W-1:0]  w_mdata;
  logic [STRB_W-1:0]  w_mstrb;
  logic               w_sready;
  logic               w_is_last;
  logic               w_beat;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic               r_len_err;

  assign w_push_cmd     = '{master: aw_master, slave: aw_slave, len: aw_len};
  assign w_push         = aw_fire & ~w_full;
  assign aw_cmd_ready   = ~w_full;
  assign w_unused_count = ^w_count;

  w_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_cmd),
    .o_rdata (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head   = w_cmd_t'(w_head_raw);
  assign w_active = ~w_empty;

  // Select the head master's W signals.
  always_comb begin
    w_mvalid = 1'b0;
    w_mlast  = 1'b0;
    w_mdata  = '0;
    w_mstrb  = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (w_head.master == MIDX_W'(k)) begin
        w_mvalid = wvalid_m[k];
        w_mlast  = wlast_m[k];
        w_mdata  = wdata_m[k*DATA_W +: DATA_W];
        w_mstrb  = wstrb_m[k*STRB_W +: STRB_W];
      end
    end
  end

  // An unmapped (zero-hot) command sinks its beats locally.
  assign w_sready  = (w_head.slave == '0) | (|(w_head.slave & wready_s));
  assign w_is_last = (r_beat_cnt == w_head.len);
  assign w_beat    = w_active & w_mvalid & w_sready;
  assign w_pop     = w_beat & w_is_last;

  always_comb begin
    wready_m = '0;
    wvalid_s = '0;
    wdata_s  = '0;
    wstrb_s  = '0;
    wlast_s  = 1'b0;
    if (w_active) begin
      wvalid_s = w_head.slave & {NUM_S{w_mvalid}};
      wdata_s  = w_mdata;
      wstrb_s  = w_mstrb;
      wlast_s  = w_is_last;
      for (int unsigned k = 0; k < NUM_M; k++) begin
        wready_m[k] = (w_head.master == MIDX_W'(k)) & w_sready;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= w_beat & (w_mlast != w_is_last);
      if (w_beat) r_beat_cnt <= w_is_last ? '0 : r_beat_cnt + LEN_W'(1);
    end
  end

  assign w_len_err = r_len_err;

endmodule

// File: tb/tb_w_route_ctrl.sv
// Bench for w_route_ctrl: directed vector table, reset-mid-burst sequence,
// then random traffic against a queue-based reference model.
module tb_w_route_ctrl;
  import w_route_ctrl_pkg::*;

  localparam int DEPTH = 2;

  logic                    clk;
  logic                    rst;
  logic                    aw_fire;
  logic [MIDX_W-1:0]       aw_master;
  logic [NUM_S-1:0]        aw_slave;
  logic [LEN_W-1:0]        aw_len;
  logic                    aw_cmd_ready;
  logic [NUM_M*DATA_W-1:0] wdata_m;
  logic [NUM_M*STRB_W-1:0] wstrb_m;
  logic [NUM_M-1:0]        wlast_m;
  logic [NUM_M-1:0]        wvalid_m;
  logic [NUM_M-1:0]        wready_m;
  logic [DATA_W-1:0]       wdata_s;
  logic [STRB_W-1:0]       wstrb_s;
  logic                    wlast_s;
  logic [NUM_S-1:0]        wvalid_s;
  logic [NUM_S-1:0]        wready_s;
  logic                    w_len_err;

  w_route_ctrl #(.CMD_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .aw_fire      (aw_fire),
    .aw_master    (aw_master),
    .aw_slave     (aw_slave),
    .aw_len       (aw_len),
    .aw_cmd_ready (aw_cmd_ready),
    .wdata_m      (wdata_m),
    .wstrb_m      (wstrb_m),
    .wlast_m      (wlast_m),
    .wvalid_m     (wvalid_m),
    .wready_m     (wready_m),
    .wdata_s      (wdata_s),
    .wstrb_s      (wstrb_s),
    .wlast_s      (wlast_s),
    .wvalid_s     (wvalid_s),
    .wready_s     (wready_s),
    .w_len_err    (w_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        fire;
    logic [1:0]  am;
    logic [6:0]  as;
    logic [3:0]  al;
    logic [2:0]  vm;
    logic [2:0]  lm;
    logic [6:0]  rs;
    logic        e_rdy;
    logic [2:0]  e_wrm;
    logic [6:0]  e_vs;
    logic        e_last;
    logic        e_err;
    int          e_ds;
  } vec_t;

  vec_t tbl [26];

  w_cmd_t mq[$];
  int     mcnt = 0;
  bit     merr = 0;

  function automatic vec_t mk(logic fire, logic [1:0] am, logic [6:0] as, logic [3:0] al,
                              logic [2:0] vm, logic [2:0] lm, logic [6:0] rs,
                              logic e_rdy, logic [2:0] e_wrm, logic [6:0] e_vs,
                              logic e_last, logic e_err, int e_ds);
    vec_t v;
    v.fire = fire; v.am = am; v.as = as; v.al = al;
    v.vm = vm; v.lm = lm; v.rs = rs;
    v.e_rdy = e_rdy; v.e_wrm = e_wrm; v.e_vs = e_vs;
    v.e_last = e_last; v.e_err = e_err; v.e_ds = e_ds;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fire, input logic [1:0] am, input logic [6:0] as,
                       input logic [3:0] al, input logic [2:0] vm, input logic [2:0] lm,
                       input logic [6:0] rs, input int tag);
    aw_fire   = fire;
    aw_master = am;
    aw_slave  = as;
    aw_len    = al;
    wvalid_m  = vm;
    wlast_m   = lm;
    wready_s  = rs;
    for (int k = 0; k < NUM_M; k++) begin
      wdata_m[k*DATA_W +: DATA_W] = {8'(k + 1), 24'(tag)};
      wstrb_m[k*STRB_W +: STRB_W] = 4'(k + 5);
    end
  endtask

  // Reference model: compare current outputs, then advance one clock.
  task automatic model_step(input int cyc);
    logic [31:0] e_d, e_s;
    logic [2:0]  e_wrm;
    logic [6:0]  e_vs;
    logic        e_last, mv, sr, beat, push_ok;
    w_cmd_t      h, c;
    e_d = 0; e_s = 0; e_wrm = 0; e_vs = 0; e_last = 0; beat = 0;
    h = '0;
    if (mq.size() != 0) begin
      h      = mq[0];
      mv     = wvalid_m[h.master];
      sr     = (h.slave == 0) || ((h.slave & wready_s) != 0);
      e_vs   = mv ? h.slave : 7'd0;
      e_wrm  = sr ? (3'b001 << h.master) : 3'b000;
      e_d    = wdata_m[h.master*DATA_W +: DATA_W];
      e_s    = 32'(wstrb_m[h.master*STRB_W +: STRB_W]);
      e_last = (mcnt == int'(h.len));
      beat   = mv && sr;
    end
    chk($sformatf("rnd%0d rdy", cyc),   32'(aw_cmd_ready), 32'(mq.size() != DEPTH));
    chk($sformatf("rnd%0d wrm", cyc),   32'(wready_m), 32'(e_wrm));
    chk($sformatf("rnd%0d vs", cyc),    32'(wvalid_s), 32'(e_vs));
    chk($sformatf("rnd%0d data", cyc),  wdata_s, e_d);
    chk($sformatf("rnd%0d strb", cyc),  32'(wstrb_s), e_s);
    chk($sformatf("rnd%0d last", cyc),  32'(wlast_s), 32'(e_last));
    chk($sformatf("rnd%0d err", cyc),   32'(w_len_err), 32'(merr));
    push_ok = aw_fire && (mq.size() < DEPTH);
    merr = beat && (wlast_m[h.master] != e_last);
    if (beat) begin
      if (e_last) begin
        mcnt = 0;
        void'(mq.pop_front());
      end else begin
        mcnt++;
      end
    end
    if (push_ok) begin
      c.master = aw_master; c.slave = aw_slave; c.len = aw_len;
      mq.push_back(c);
    end
  endtask

  initial begin
    logic [31:0] e_d, e_s;
    logic [6:0]  r_as;
    int          r;

    tbl[0]  = mk(0,0,7'h00,0, 3'b000,3'b000,7'h00, 1,3'b000,7'h00,0,0,-1);
    tbl[1]  = mk(1,1,7'h04,3, 3'b000,3'b000,7'h00, 1,3'b000,7'h00,0,0,-1);
    tbl[2]  = mk(0,0,7'h00,0, 3'b010,3'b000,7'h04, 1,3'b010,7'h04,0,0,1);
    tbl[3]  = mk(0,0,7'h00,0, 3'b010,3'b000,7'h04, 1,3'b010,7'h04,0,0,1);
    tbl[4]  = mk(0,0,7'h00,0, 3'b010,3'b000,7'h04, 1,3'b010,7'h04,0,0,1);
    tbl[5]  = mk(0,0,7'h00,0, 3'b010,3'b010,7'h04, 1,3'b010,7'h04,1,0,1);
    tbl[6]  = mk(0,0,7'h00,0, 3'b000,3'b000,7'h00, 1,3'b000,7'h00,0,0,-1);
    tbl[7]  = mk(1,0,7'h01,1, 3'b000,3'b000,7'h00, 1,3'b000,7'h00,0,0,-1);
    tbl[8]  = mk(0,0,7'h00,0, 3'b001,3'b001,7'h01, 1,3'b001,7'h01,0,0,0);
    tbl[9]  = mk(0,0,7'h00,0, 3'b001,3'b001,7'h01, 1,3'b001,7'h01,1,1,0);
    tbl[10] = mk(0,0,7'h00,0, 3'b000,3'b000,7'h00, 1,3'b000,7'h00,0,0,-1);
    tbl[11] = mk(1,1,7'h00,2, 3'b000,3'b000,7'h00, 1,3'b000,7'h00,0,0,-1);
    tbl[12] = mk(0,0,7'h00,0, 3'b010,3'b000,7'h7F, 1,3'b010,7'h00,0,0,1);
    tbl[13] = mk(0,0,7'h00,0, 3'b010,3'b000,7'h7F, 1,3'b010,7'h00,0,0,1);
    tbl[14] = mk(0,0,7'h00,0, 3'b010,3'b010,7'h7F, 1,3'b010,7'h00,1,0,1);
    tbl[15] = mk(0,0,7'h00,0, 3'b000,3'b000,7'h00, 1,3'b000,7'h00,0,0,-1);
    tbl[16] = mk(1,0,7'h02,0, 3'b000,3'b000,7'h00, 1,3'b000,7'h00,0,0,-1);
    tbl[17] = mk(1,2,7'h08,1, 3'b101,3'b000,7'h00, 1,3'b000,7'h02,1,0,0);
    tbl[18] = mk(0,0,7'h00,0, 3'b101,3'b000,7'h00, 0,3'b000,7'h02,1,0,0);
    tbl[19] = mk(0,0,7'h00,0, 3'b101,3'b000,7'h00, 0,3'b000,7'h02,1,0,0);
    tbl[20] = mk(0,0,7'h00,0, 3'b101,3'b000,7'h00, 0,3'b000,7'h02,1,0,0);
    tbl[21] = mk(0,0,7'h00,0, 3'b101,3'b000,7'h00, 0,3'b000,7'h02,1,0,0);
    tbl[22] = mk(1,1,7'h10,5, 3'b101,3'b001,7'h02, 0,3'b001,7'h02,1,0,0);
    tbl[23] = mk(0,0,7'h00,0, 3'b100,3'b000,7'h08, 1,3'b100,7'h08,0,0,2);
    tbl[24] = mk(0,0,7'h00,0, 3'b100,3'b100,7'h08, 1,3'b100,7'h08,1,0,2);
    tbl[25] = mk(0,0,7'h00,0, 3'b000,3'b000,7'h00, 1,3'b000,7'h00,0,0,-1);

    rst = 1'b0;
    drive(0, 0, 7'h00, 0, 3'b000, 3'b000, 7'h00, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Directed table
    for (int i = 0; i < 26; i++) begin
      @(posedge clk);
      #1 drive(tbl[i].fire, tbl[i].am, tbl[i].as, tbl[i].al,
               tbl[i].vm, tbl[i].lm, tbl[i].rs, i);
      @(negedge clk);
      e_d = 0; e_s = 0;
      if (tbl[i].e_ds >= 0) begin
        e_d = {8'(tbl[i].e_ds + 1), 24'(i)};
        e_s = 32'(tbl[i].e_ds + 5);
      end
      chk($sformatf("row%0d rdy", i),  32'(aw_cmd_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d wrm", i),  32'(wready_m), 32'(tbl[i].e_wrm));
      chk($sformatf("row%0d vs", i),   32'(wvalid_s), 32'(tbl[i].e_vs));
      chk($sformatf("row%0d data", i), wdata_s, e_d);
      chk($sformatf("row%0d strb", i), 32'(wstrb_s), e_s);
      chk($sformatf("row%0d last", i), 32'(wlast_s), 32'(tbl[i].e_last));
      chk($sformatf("row%0d err", i),  32'(w_len_err), 32'(tbl[i].e_err));
    end

    // Reset asserted mid-burst on an unmapped command
    @(posedge clk); #1 drive(1, 1, 7'h00, 2, 3'b000, 3'b000, 7'h00, 100);
    @(posedge clk); #1 drive(0, 0, 7'h00, 0, 3'b010, 3'b000, 7'h00, 101);
    @(negedge clk);
    chk("zh wrm", 32'(wready_m), 32'(3'b010));
    chk("zh vs", 32'(wvalid_s), 32'd0);
    @(posedge clk); #1 drive(0, 0, 7'h00, 0, 3'b010, 3'b000, 7'h00, 102);
    #2 rst = 1'b0;
    #1;
    chk("arst wrm", 32'(wready_m), 32'd0);
    chk("arst vs", 32'(wvalid_s), 32'd0);
    chk("arst data", wdata_s, 32'd0);
    chk("arst last", 32'(wlast_s), 32'd0);
    chk("arst rdy", 32'(aw_cmd_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    drive(0, 0, 7'h00, 0, 3'b010, 3'b000, 7'h00, 103);
    @(negedge clk);
    chk("post-rst wrm", 32'(wready_m), 32'd0);
    chk("post-rst err", 32'(w_len_err), 32'd0);
    @(posedge clk); #1 drive(1, 1, 7'h04, 1, 3'b000, 3'b000, 7'h00, 104);
    @(posedge clk); #1 drive(0, 0, 7'h00, 0, 3'b010, 3'b000, 7'h04, 105);
    @(negedge clk);
    chk("post-rst cnt0 last", 32'(wlast_s), 32'd0);
    chk("post-rst cnt0 wrm", 32'(wready_m), 32'(3'b010));
    @(posedge clk); #1 drive(0, 0, 7'h00, 0, 3'b010, 3'b010, 7'h04, 106);
    @(negedge clk);
    chk("post-rst cnt1 last", 32'(wlast_s), 32'd1);
    @(posedge clk); #1 drive(0, 0, 7'h00, 0, 3'b000, 3'b000, 7'h00, 107);
    @(negedge clk);
    chk("post-rst idle wrm", 32'(wready_m), 32'd0);
    chk("post-rst idle err", 32'(w_len_err), 32'd0);
    chk("post-rst idle rdy", 32'(aw_cmd_ready), 32'd1);

    // Random traffic against the reference model
    mq.delete();
    mcnt = 0;
    merr = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      r    = int'($urandom % 8);
      r_as = (r == 7) ? 7'd0 : 7'(1 << r);
      aw_fire   = ($urandom % 3) == 0;
      aw_master = 2'($urandom % 3);
      aw_slave  = r_as;
      aw_len    = (($urandom % 8) == 0) ? 4'd15 : 4'($urandom % 4);
      wvalid_m  = 3'($urandom);
      wlast_m   = 3'($urandom);
      wready_s  = 7'($urandom);
      for (int k = 0; k < NUM_M; k++) begin
        wdata_m[k*DATA_W +: DATA_W] = $urandom;
        wstrb_m[k*STRB_W +: STRB_W] = 4'($urandom);
      end
      @(negedge clk);
      model_step(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/w_route_ctrl.md
Name: w_route_ctrl

Overview:
- Write-data (W) routing stage of the AXI interconnect, directly downstream of the AW channel.
- Accepts each completed AW handshake as a routing command: master index, one-hot slave select and burst length.
- Queues commands in order and steers W beats from the owning master to the selected slave.
- Regenerates WLAST from the beat count and flags master WLAST mismatches.

Parameters:
- NUM_M, 3, number of masters.
- NUM_S, 7, number of slaves (one-hot select width).
- DATA_W, 32, WDATA width; strobe width is DATA_W/8.
- LEN_W, 4, AWLEN width.
- CMD_DEPTH, 2, command queue depth (power of 2, at least 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- aw_fire  in  1  AW handshake to some slave this cycle (OR of AWVALID_Sx&AWREADY_Sx).
- aw_master  in  2  master index of the AW transfer (0..NUM_M-1).
- aw_slave  in  NUM_S  one-hot slave select of the AW transfer.
- aw_len  in  LEN_W  AWLEN of the AW transfer.
- aw_cmd_ready  out  1  queue not full; AW channel must gate slave AWVALID with it.
- wdata_m  in  NUM_M*DATA_W  packed master WDATA, master k at slice k.
- wstrb_m  in  NUM_M*DATA_W/8  packed master WSTRB.
- wlast_m  in  NUM_M  master WLAST.
- wvalid_m  in  NUM_M  master WVALID.
- wready_m  out  NUM_M  master WREADY.
- wdata_s  out  DATA_W  shared slave WDATA.
- wstrb_s  out  DATA_W/8  shared slave WSTRB.
- wlast_s  out  1  regenerated WLAST.
- wvalid_s  out  NUM_S  per-slave WVALID.
- wready_s  in  NUM_S  per-slave WREADY.
- w_len_err  out  1  one-cycle pulse on WLAST mismatch.

Behaviour:
- Reset (rst=0, async): queue empty, beat count 0, w_len_err=0.
  - Consequently wready_m=0, wvalid_s=0, wlast_s=0, wdata_s=0, wstrb_s=0, aw_cmd_ready=1.
- Queue: circular FIFO of {master, slave, len} with rd/wr pointers plus an occupancy counter.
  - Push when aw_fire & aw_cmd_ready.
  - aw_fire while full: command is dropped and the entry is not written. This is a protocol violation because AW must be gated by aw_cmd_ready.
  - aw_cmd_ready = (occupancy != CMD_DEPTH), registered-state derived. There is no same-cycle pop bypass: when full, ready stays low for the cycle in which the pop occurs.
- Routing (combinational from the head entry, active only when the queue is non-empty; head = {hm, hs, hlen}):
  - wvalid_s = hs & {NUM_S{wvalid_m[hm]}}.
  - wready_m[hm] = |(hs & wready_s); other masters' wready_m = 0.
  - wdata_s and wstrb_s = master hm slice; both are 0 when the queue is empty.
  - wlast_s = (beat_cnt == hlen) when non-empty.
- Zero-hot slave select (hs == 0), the unmapped-address case:
  - wready_m[hm] = 1 and wvalid_s = 0.
  - Beats are counted and discarded.
- Latency: a command pushed in cycle N can route beats from cycle N+1. W beats presented before their AW is queued are stalled.
- Beat handshake: beat = wvalid_m[hm] & wready_m[hm].
  - On a beat with beat_cnt != hlen: beat_cnt increments.
  - On a beat with beat_cnt == hlen: beat_cnt returns to 0 and the head is popped.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- Mismatch: w_len_err pulses for 1 cycle after any beat where wlast_m[hm] != (beat_cnt == hlen). The burst still completes on the count; master WLAST never changes routing.
- Width rules:
  - beat_cnt is LEN_W bits and never wraps beyond hlen; hlen = 15 gives 16 beats.
  - Pointers are log2(CMD_DEPTH) bits and wrap naturally.
- Data is not registered; this stage adds no latency on the W path.
- Reset mid-burst: queue and count are cleared immediately, all valid/ready outputs drop asynchronously, and in-flight beats are lost.

Decomposition:
- Shared package (AXI defines header), holding:
  - AXI widths: ID, ADDR, DATA, STRB, LEN.
  - NUM_M and NUM_S.
  - Master-index width.
  - A packed struct w_cmd_t {master, slave, len}.
- One natural sub-module: w_cmd_fifo (parameterised depth/width FIFO with full/empty/occupancy), reusable later by the B-response routing stage.
- Routing mux and beat counter stay in the top.

Test Plan:
- Reset then idle: after rst release, aw_cmd_ready=1, all wvalid_s=0, all wready_m=0, wdata_s=0.
- Single burst: push {m=1, s=0000100, len=3}; M1 sends 4 beats D0..D3 with wlast on D3, slave 2 always ready.
  - Required: wvalid_s[2] high for 4 beats and wdata_s = D0..D3.
  - Required: wlast_s only on beat 4, queue empty afterwards, w_len_err never pulses.
- Backpressure and fill:
  - Push 2 commands {m0, s1, len0} and {m2, s3, len1}: aw_cmd_ready=0 once full.
  - Hold wready_s[1]=0 for 5 cycles: M0 is stalled and M2 data is not forwarded.
  - After the M0 beat completes: aw_cmd_ready=1 the next cycle, and M2 routes to slave 3 on 2 beats.
- Simultaneous push/pop: while full with the last beat handshaking, aw_fire is presented. Required: ignored since aw_cmd_ready=0, so no push occurs; occupancy drops by 1.
- WLAST mismatch: {m0, s0, len=1}, M0 asserts wlast on beat 1. Required: w_len_err pulses once, wlast_s high on beat 2, pop after beat 2.
- Zero-hot slave: {m1, s=0, len=2}. Required: wready_m[1]=1 for 3 beats, wvalid_s all 0, then pop; reset asserted mid-burst clears all outputs.
